// File: rtl/posit_mul_sched_es3_if.sv
// posit_mul_sched_es3_if: operand, multiplier and result signals of the
// two-requester posit multiplier scheduler.
// value (20b)         = {sgn, inf, zero, scale[8:0] signed, fraction[7:0]}
// value_product (30b) = {sgn, inf, zero, scale[10:0] signed, fraction[15:0]}
interface posit_mul_sched_es3_if;
  localparam int VW = 20;
  localparam int PW = 30;

  logic          a_valid;
  logic          a_ready;
  logic [VW-1:0] a_in1;
  logic [VW-1:0] a_in2;
  logic          b_valid;
  logic          b_ready;
  logic [VW-1:0] b_in1;
  logic [VW-1:0] b_in2;
  logic          mul_valid;
  logic [VW-1:0] mul_in1;
  logic [VW-1:0] mul_in2;
  logic [PW-1:0] mul_result;
  logic          a_res_valid;
  logic          a_res_ready;
  logic [VW-1:0] a_res;
  logic          b_res_valid;
  logic          b_res_ready;
  logic [VW-1:0] b_res;

  modport master (
    output a_valid, a_in1, a_in2, b_valid, b_in1, b_in2, mul_result,
           a_res_ready, b_res_ready,
    input  a_ready, b_ready, mul_valid, mul_in1, mul_in2,
           a_res_valid, a_res, b_res_valid, b_res
  );

  modport slave (
    input  a_valid, a_in1, a_in2, b_valid, b_in1, b_in2, mul_result,
           a_res_ready, b_res_ready,
    output a_ready, b_ready, mul_valid, mul_in1, mul_in2,
           a_res_valid, a_res, b_res_valid, b_res
  );
endinterface

// File: rtl/posit_mul_sched_es3.sv
// posit_mul_sched_es3: round-robin scheduler sharing one LAT-cycle es3 posit
// multiplier between requesters A and B, with credit-protected per-requester
// result FIFOs. Optional macro POSIT_SCALE_SAT_EN saturates the converted
// scale to [-256, 255] instead of truncating it to 9 bits.
module posit_mul_sched_es3 #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  posit_mul_sched_es3_if.slave bus
);
  localparam int FBITS  = 8;
  localparam int MBITS  = 16;
  localparam int SBITS  = 9;
  localparam int PSBITS = 11;
  localparam int VW     = 3 + SBITS + FBITS;
  localparam int PW     = 3 + PSBITS + MBITS;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  // value_product -> value: flags copied, fraction keeps its top FBITS bits.
  function automatic logic [VW-1:0] conv(input logic [PW-1:0] p);
    logic signed [PSBITS-1:0] s;
    logic [SBITS-1:0]         so;
    s = p[PW-4 -: PSBITS];
`ifdef POSIT_SCALE_SAT_EN
    if (s > 11'sd255)       so = 9'h0FF;
    else if (s < -11'sd256) so = 9'h100;
    else                    so = s[SBITS-1:0];
`else
    so = s[SBITS-1:0];
`endif
    return {p[PW-1], p[PW-2], p[PW-3], so, p[MBITS-1 -: FBITS]};
  endfunction

  logic          last_b_q;               // last grant went to B
  logic [LAT-1:0] tv_q, tid_q;           // tag pipe: valid / id (1 = B)
  logic [CW-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [AW-1:0] wp_a_q, rp_a_q, wp_b_q, rp_b_q;
  logic [VW-1:0] mem_a_q [DEPTH];
  logic [VW-1:0] mem_b_q [DEPTH];

  logic [CW:0] sum_a, sum_b;
  logic elig_a, elig_b, gnt_a, gnt_b;
  logic wr_a, wr_b, pop_a, pop_b;
  logic [VW-1:0] wdata;

  assign sum_a  = {1'b0, out_a_q} + {1'b0, cnt_a_q};
  assign sum_b  = {1'b0, out_b_q} + {1'b0, cnt_b_q};
  assign elig_a = bus.a_valid && (sum_a < LIMIT);
  assign elig_b = bus.b_valid && (sum_b < LIMIT);
  assign wr_a   = tv_q[LAT-1] && !tid_q[LAT-1];
  assign wr_b   = tv_q[LAT-1] &&  tid_q[LAT-1];
  assign wdata  = conv(bus.mul_result);
  assign pop_a  = bus.a_res_valid && bus.a_res_ready;
  assign pop_b  = bus.b_res_valid && bus.b_res_ready;

  // Round-robin arbitration; reset suppresses any grant in the same cycle.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else if (elig_a && elig_b) begin
      gnt_a = last_b_q;
      gnt_b = !last_b_q;
    end else begin
      gnt_a = elig_a;
      gnt_b = elig_b;
    end
  end

  // Credit counters: in-flight issues and FIFO occupancy per requester.
  always_comb begin
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (gnt_a && !wr_a)      out_a_d = out_a_q + CW'(1);
    else if (!gnt_a && wr_a) out_a_d = out_a_q - CW'(1);
    else                     out_a_d = out_a_q;
    if (gnt_b && !wr_b)      out_b_d = out_b_q + CW'(1);
    else if (!gnt_b && wr_b) out_b_d = out_b_q - CW'(1);
    else                     out_b_d = out_b_q;
    if (wr_a && !pop_a)      cnt_a_d = cnt_a_q + CW'(1);
    else if (!wr_a && pop_a) cnt_a_d = cnt_a_q - CW'(1);
    else                     cnt_a_d = cnt_a_q;
    if (wr_b && !pop_b)      cnt_b_d = cnt_b_q + CW'(1);
    else if (!wr_b && pop_b) cnt_b_d = cnt_b_q - CW'(1);
    else                     cnt_b_d = cnt_b_q;
  end

  // Control state: pointer, tag pipe, counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
      tv_q     <= '0;
      tid_q    <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      wp_a_q   <= '0;
      rp_a_q   <= '0;
      wp_b_q   <= '0;
      rp_b_q   <= '0;
    end else begin
      if (gnt_a)      last_b_q <= 1'b0;
      else if (gnt_b) last_b_q <= 1'b1;
      else            last_b_q <= last_b_q;
      tv_q[0]  <= gnt_a || gnt_b;
      tid_q[0] <= gnt_b;
      for (int i = 1; i < LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      if (wr_a)  wp_a_q <= wp_a_q + AW'(1);
      if (pop_a) rp_a_q <= rp_a_q + AW'(1);
      if (wr_b)  wp_b_q <= wp_b_q + AW'(1);
      if (pop_b) rp_b_q <= rp_b_q + AW'(1);
    end
  end

  // FIFO storage: converted results land at the write pointer of their owner.
  always_ff @(posedge clk) begin
    if (!reset && wr_a) mem_a_q[wp_a_q] <= wdata;
    if (!reset && wr_b) mem_b_q[wp_b_q] <= wdata;
  end

  assign bus.a_ready     = gnt_a;
  assign bus.b_ready     = gnt_b;
  assign bus.mul_valid   = gnt_a || gnt_b;
  assign bus.mul_in1     = gnt_b ? bus.b_in1 : bus.a_in1;
  assign bus.mul_in2     = gnt_b ? bus.b_in2 : bus.a_in2;
  assign bus.a_res_valid = (cnt_a_q != '0);
  assign bus.b_res_valid = (cnt_b_q != '0);
  assign bus.a_res       = mem_a_q[rp_a_q];
  assign bus.b_res       = mem_b_q[rp_b_q];
endmodule

// File: tb/tb_posit_mul_sched_es3.sv
// tb_posit_mul_sched_es3: directed phases plus randomized traffic against a
// transaction-level model (credits = issued - popped, result queues per
// requester, multiplier output paired with the issue made LAT cycles earlier).
module tb_posit_mul_sched_es3;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  posit_mul_sched_es3_if bus();

  posit_mul_sched_es3 #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // model state
  int          issued [2];
  int          popped [2];
  bit          last_b;
  int          pipe [$];
  logic [19:0] qa [$];
  logic [19:0] qb [$];

  // product override for directed phases
  bit                 ov_en;
  logic               ov_sgn, ov_inf, ov_zero;
  logic signed [10:0] ov_scale;
  logic [15:0]        ov_frac;

  // snapshots of the last sampled cycle
  logic        s_a_ready, s_a_res_valid;
  logic [19:0] s_a_res;
  int          cnt_ga;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_conv(input logic [29:0] p);
    int s;
    logic [8:0] so;
    s = int'($signed(p[26:16]));
`ifdef POSIT_SCALE_SAT_EN
    if (s > 255) s = 255;
    else if (s < -256) s = -256;
`endif
    so = s[8:0];
    return {p[29], p[28], p[27], so, p[15:8]};
  endfunction

  task automatic model_clear();
    issued[0] = 0; issued[1] = 0;
    popped[0] = 0; popped[1] = 0;
    last_b = 1'b1;
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back(0);
    qa.delete();
    qb.delete();
  endtask

  task automatic step();
    logic [31:0] r;
    logic [29:0] prod;
    bit ea, eb, ga, gb, pa, pb;
    int who;
    r = $urandom; bus.a_in1 = r[19:0];
    r = $urandom; bus.a_in2 = r[19:0];
    r = $urandom; bus.b_in1 = r[19:0];
    r = $urandom; bus.b_in2 = r[19:0];
    r = $urandom; prod = r[29:0];
    if (ov_en) prod = {ov_sgn, ov_inf, ov_zero, ov_scale, ov_frac};
    bus.mul_result = prod;
    @(negedge clk);
    s_a_ready     = bus.a_ready;
    s_a_res_valid = bus.a_res_valid;
    s_a_res       = bus.a_res;
    if (bus.a_ready === 1'b1) cnt_ga++;
    if (reset) begin
      chk("rst_a_ready", 32'(bus.a_ready), 32'(0));
      chk("rst_b_ready", 32'(bus.b_ready), 32'(0));
      chk("rst_mul_valid", 32'(bus.mul_valid), 32'(0));
      model_clear();
    end else begin
      ea = bus.a_valid && (issued[0] - popped[0] < DEPTH);
      eb = bus.b_valid && (issued[1] - popped[1] < DEPTH);
      ga = ea && (!eb || last_b);
      gb = eb && (!ea || !last_b);
      chk("a_ready", 32'(bus.a_ready), 32'(ga));
      chk("b_ready", 32'(bus.b_ready), 32'(gb));
      chk("mul_valid", 32'(bus.mul_valid), 32'(ga || gb));
      if (ga) begin
        chk("mul_in1_a", 32'(bus.mul_in1), 32'(bus.a_in1));
        chk("mul_in2_a", 32'(bus.mul_in2), 32'(bus.a_in2));
      end
      if (gb) begin
        chk("mul_in1_b", 32'(bus.mul_in1), 32'(bus.b_in1));
        chk("mul_in2_b", 32'(bus.mul_in2), 32'(bus.b_in2));
      end
      chk("a_res_valid", 32'(bus.a_res_valid), 32'(qa.size() != 0));
      chk("b_res_valid", 32'(bus.b_res_valid), 32'(qb.size() != 0));
      pa = (qa.size() != 0) && bus.a_res_ready;
      pb = (qb.size() != 0) && bus.b_res_ready;
      if (pa) begin
        chk("a_res", 32'(bus.a_res), 32'(qa[0]));
        void'(qa.pop_front());
        popped[0]++;
      end
      if (pb) begin
        chk("b_res", 32'(bus.b_res), 32'(qb[0]));
        void'(qb.pop_front());
        popped[1]++;
      end
      who = pipe.pop_front();
      if (who == 1) begin
        qa.push_back(ref_conv(prod));
        chk("fifo_a_no_overflow", 32'(qa.size() <= DEPTH), 32'(1));
      end else if (who == 2) begin
        qb.push_back(ref_conv(prod));
        chk("fifo_b_no_overflow", 32'(qb.size() <= DEPTH), 32'(1));
      end
      pipe.push_back(ga ? 1 : (gb ? 2 : 0));
      if (ga) begin issued[0]++; last_b = 1'b0; end
      if (gb) begin issued[1]++; last_b = 1'b1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.a_res_ready = 1'b1; bus.b_res_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.a_res_ready = 1'b1; bus.b_res_ready = 1'b1;
    ov_en = 1'b0; ov_sgn = 1'b0; ov_inf = 1'b0; ov_zero = 1'b0;
    ov_scale = 11'sd0; ov_frac = 16'h0000;
    cnt_ga = 0;
    model_clear();
    #1;
    step(); step();
    reset = 1'b0;
    chk("post_rst_a_res_valid", 32'(bus.a_res_valid), 32'(0));
    chk("post_rst_b_res_valid", 32'(bus.b_res_valid), 32'(0));

    // single A issue, known product
    ov_en = 1'b1; ov_scale = 11'sd5; ov_frac = 16'hA5C3;
    bus.a_valid = 1'b1;
    step();
    chk("single_a_ready", 32'(s_a_ready), 32'(1));
    bus.a_valid = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    chk("single_not_early", 32'(s_a_res_valid), 32'(0));
    step();
    chk("single_valid", 32'(s_a_res_valid), 32'(1));
    chk("single_scale", 32'(s_a_res[16:8]), 32'(5));
    chk("single_frac", 32'(s_a_res[7:0]), 32'(8'hA5));
    ov_en = 1'b0;
    idle(3);

    // contention: alternating grants, in-order returns
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int i = 0; i < 6; i++) step();
    idle(LAT + 4);

    // backpressure on A
    cnt_ga = 0;
    bus.a_res_ready = 1'b0;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("bp_a_grants", 32'(cnt_ga), 32'(DEPTH));
    bus.a_res_ready = 1'b1;
    step();
    bus.a_res_ready = 1'b0;
    step();
    chk("bp_regrant", 32'(s_a_ready), 32'(1));
    step();
    chk("bp_hold", 32'(s_a_ready), 32'(0));
    idle(LAT + 2 * DEPTH + 4);

    // scale saturation / truncation
    ov_en = 1'b1; ov_frac = 16'h1234;
    ov_scale = 11'sd300;
    bus.a_valid = 1'b1; step(); bus.a_valid = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    ov_scale = -11'sd300;
    bus.b_valid = 1'b1; step(); bus.b_valid = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();
    ov_en = 1'b0;

    // reset mid-flight
    bus.a_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.a_valid = 1'b0;
    step(); step();
    reset = 1'b1; bus.a_valid = 1'b1;
    step();
    reset = 1'b0; bus.a_valid = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      chk("post_reset_no_stale", 32'(s_a_res_valid), 32'(0));
    end
    bus.a_valid = 1'b1; step(); bus.a_valid = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    step();
    chk("post_reset_return", 32'(s_a_res_valid), 32'(1));
    idle(2);

    // inf then zero passthrough with sign
    ov_en = 1'b1; ov_scale = 11'sd0; ov_frac = 16'h0000;
    ov_sgn = 1'b1; ov_inf = 1'b1; ov_zero = 1'b0;
    bus.a_valid = 1'b1; step(); bus.a_valid = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    ov_sgn = 1'b0; ov_inf = 1'b0; ov_zero = 1'b1;
    bus.b_valid = 1'b1; step(); bus.b_valid = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();
    ov_en = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.a_valid = 1'($urandom_range(0, 1));
      bus.b_valid = 1'($urandom_range(0, 1));
      bus.a_res_ready = ($urandom_range(0, 9) < 7);
      bus.b_res_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    idle(LAT + 2 * DEPTH + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
